ps2_key_event_decoder: RTL and testbench
========================================

// Module: ps2_key_event_decoder
// PURPOSE
//  Consumes raw PS/2 scan-code bytes popped from the ps2_keyboard FIFO (data/ready/nextdata_n)
//  and folds Set-2 prefixes (E0 = extended, F0 = break) into complete key events.
//  Events are buffered in a small FIFO read by the CPU-side keyboard MMIO register.
//  Format matches the NPC keyboard device: {valid, keydown, ext, code}; 0 when empty.
// PARAMETERS
//  EVQ_AW    2             event FIFO address width; depth = 2**EVQ_AW (min 1)
// PORTS
//  clk            in   1          system clock, all logic on posedge
//  clrn           in   1          asynchronous active-low reset
//  kbd_data       in   8          scan byte at keyboard FIFO head (ps2_keyboard.data)
//  kbd_ready      in   1          keyboard FIFO non-empty (ps2_keyboard.ready)
//  kbd_nextdata_n out  1          active-low pop strobe to ps2_keyboard
//  ev_rd          in   1          pop head event (ignored when empty)
//  ev_data        out  16         [15]=valid [10]=0 [9]=keydown [8]=ext [7:0]=code; 0 if empty
//  ev_count       out  EVQ_AW+1   events queued, 0..2**EVQ_AW
//  proto_err      out  1          sticky: illegal byte/sequence seen
//  clr_err        in   1          synchronous clear of proto_err
// BEHAVIOUR
//  Reset (clrn=0, async): fetch FSM=FETCH, prefix FSM=IDLE, FIFO ptrs=0, proto_err=0;
//   outputs: kbd_nextdata_n=1, ev_data=0, ev_count=0.
//  Fetch FSM (2 states):
//   FETCH: if kbd_ready && ev_count<DEPTH -> kbd_nextdata_n=0 (combinational, this cycle only),
//          latch kbd_data into byte_q, go DECODE; else stay, kbd_nextdata_n=1.
//   DECODE: kbd_nextdata_n=1 (lets ps2_keyboard update r_ptr/ready); decode byte_q,
//          push event (if any) at end of cycle; go FETCH. Max 1 byte per 2 clk.
//   Queue full -> no pop; bytes stay in ps2_keyboard FIFO (its overflow flag covers loss).
//  Prefix FSM (IDLE, E0, F0, E0F0), applied in DECODE to byte b:
//   b==00 or FF (kbd error/overrun): no event, proto_err<=1, -> IDLE.
//   b==E0: IDLE->E0; E0->E0; F0 or E0F0 -> proto_err<=1, ->E0.
//   b==F0: IDLE->F0; E0->E0F0; F0/E0F0 stay (proto_err<=1).
//   other b: push event, ->IDLE: IDLE {1,keydown=1,ext=0,b}; E0 {1,1,1,b};
//            F0 {1,0,0,b}; E0F0 {1,0,1,b}.
//   No make/break filtering; typematic repeats produce repeated make events.
//  Event FIFO: wr/rd ptrs EVQ_AW+1 bits, full = MSB differ & rest equal, empty = equal.
//   ev_data = empty ? 16'h0000 : {1'b1, 5'b0, mem[rd][9:0]} combinational from head.
//   ev_rd && !empty -> rd ptr +1 at clock edge. ev_rd when empty: no effect.
//   Push and pop same cycle: both take effect, ev_count unchanged. Pop in cycle N is
//   visible to the fetch FSM as freed space in cycle N+1.
//  Latency: kbd_ready with byte in cycle N (FETCH, space) -> event on ev_data in cycle N+2.
//  clr_err and a new error in the same cycle: set wins.
//  Reset mid-sequence discards prefix state and byte_q; queued events lost.
// TESTING
//  1. Byte 1C -> one pop pulse (1 clk low), 2 clk later ev_data=16'h821C, ev_count=1; ev_rd -> 0000.
//  2. F0,1C -> ev_data=16'h801C, exactly one event; E0,75 -> 16'h8375; E0,F0,75 -> 16'h8175.
//  3. Push 4 events (EVQ_AW=2) with 5th byte waiting: kbd_nextdata_n stays 1, ev_count=4;
//     one ev_rd -> 5th byte fetched next cycle, order preserved (wrap-around checked).
//  4. Byte 00, then F0,E0,74 -> proto_err=1, no event for 00, event 16'h8374 (E0 restart); clr_err -> 0.
//  5. ev_rd asserted same cycle as push on full-1 queue -> ev_count unchanged, no lost event.
//  6. Assert clrn low after E0 accepted, release, send 75 -> ev_data=16'h8275 (no ext bit).

Source files
------------

// File: rtl/ps2_key_event_decoder_if.sv
// ps2_key_event_decoder_if: keyboard-FIFO side and CPU event side of the
// scan-code decoder. The slave modport is the decoder, master is its user.
//   kbd_data/kbd_ready/kbd_nextdata_n : ps2_keyboard FIFO head and pop strobe
//   ev_rd/ev_data/ev_count            : event FIFO read port and fill level
//   proto_err/clr_err                 : sticky protocol error and its clear
interface ps2_key_event_decoder_if #(
    parameter int EVQ_AW = 2
);
    logic [7:0]      kbd_data;
    logic            kbd_ready;
    logic            kbd_nextdata_n;
    logic            ev_rd;
    logic [15:0]     ev_data;
    logic [EVQ_AW:0] ev_count;
    logic            proto_err;
    logic            clr_err;

    modport master (
        output kbd_data,
        output kbd_ready,
        output ev_rd,
        output clr_err,
        input  kbd_nextdata_n,
        input  ev_data,
        input  ev_count,
        input  proto_err
    );

    modport slave (
        input  kbd_data,
        input  kbd_ready,
        input  ev_rd,
        input  clr_err,
        output kbd_nextdata_n,
        output ev_data,
        output ev_count,
        output proto_err
    );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: folds PS/2 Set-2 scan bytes (E0/F0 prefixes) into
// key events {valid, keydown, ext, code} queued in a small FIFO.
//   clk  : system clock, rising edge
//   clrn : asynchronous active-low reset
//   bus  : ps2_key_event_decoder_if.slave (keyboard FIFO + event port);
//          the interface EVQ_AW must equal this module's EVQ_AW
module ps2_key_event_decoder #(
    parameter int EVQ_AW = 2
) (
    input  logic                    clk,
    input  logic                    clrn,
    ps2_key_event_decoder_if.slave  bus
);
    localparam int DEPTH = 1 << EVQ_AW;
    localparam int PW    = EVQ_AW + 1;
    localparam int IW    = (EVQ_AW > 0) ? EVQ_AW : 1;

    typedef enum logic {
        FETCH,
        DECODE
    } fetch_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_E0,
        P_F0,
        P_E0F0
    } pfx_e;

    fetch_e        fetch_q, fetch_d;
    pfx_e          pfx_q, pfx_d;
    logic [7:0]    byte_q, byte_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          err_q, err_d;

    logic [9:0]    mem [DEPTH];

    logic [PW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop_kbd;
    logic          rd_fire;
    logic          push;
    logic          set_err;
    logic [9:0]    ev_word;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign count = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (count == PW'(DEPTH));

    // Mask keeps index zero when the queue is a single entry.
    assign wr_idx = IW'(wr_q) & IW'(DEPTH - 1);
    assign rd_idx = IW'(rd_q) & IW'(DEPTH - 1);

    // A byte is only taken while a free slot exists, so the push in the
    // following DECODE cycle can never overflow the queue.
    assign pop_kbd = (fetch_q == FETCH) && bus.kbd_ready && !full;
    assign rd_fire = bus.ev_rd && !empty;

    always_comb begin
        push    = 1'b0;
        set_err = 1'b0;
        ev_word = '0;
        pfx_d   = pfx_q;
        if (fetch_q == DECODE) begin
            unique case (1'b1)
                (byte_q == 8'h00) || (byte_q == 8'hFF): begin
                    set_err = 1'b1;
                    pfx_d   = P_IDLE;
                end
                (byte_q == 8'hE0): begin
                    // A stray E0 after a break prefix restarts as extended.
                    if (pfx_q == P_F0 || pfx_q == P_E0F0) begin
                        set_err = 1'b1;
                    end
                    pfx_d = P_E0;
                end
                (byte_q == 8'hF0): begin
                    if (pfx_q == P_IDLE) begin
                        pfx_d = P_F0;
                    end else if (pfx_q == P_E0) begin
                        pfx_d = P_E0F0;
                    end else begin
                        set_err = 1'b1;
                    end
                end
                default: begin
                    push    = 1'b1;
                    ev_word = {
                        (pfx_q == P_IDLE) || (pfx_q == P_E0),
                        (pfx_q == P_E0) || (pfx_q == P_E0F0),
                        byte_q
                    };
                    pfx_d   = P_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fetch_d = fetch_q;
        byte_d  = byte_q;
        unique case (fetch_q)
            FETCH: begin
                if (pop_kbd) begin
                    fetch_d = DECODE;
                    byte_d  = bus.kbd_data;
                end
            end
            DECODE: begin
                fetch_d = FETCH;
            end
            default: begin
                fetch_d = FETCH;
            end
        endcase
    end

    always_comb begin
        wr_d  = wr_q + PW'(push);
        rd_d  = rd_q + PW'(rd_fire);
        err_d = err_q;
        if (bus.clr_err) begin
            err_d = 1'b0;
        end
        if (set_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_q <= FETCH;
            pfx_q   <= P_IDLE;
            byte_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            fetch_q <= fetch_d;
            pfx_q   <= pfx_d;
            byte_q  <= byte_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= ev_word;
        end
    end

    assign bus.kbd_nextdata_n = !pop_kbd;
    assign bus.ev_data   = empty ? 16'h0000
                                 : {1'b1, 5'b0, mem[rd_idx]};
    assign bus.ev_count  = count;
    assign bus.proto_err = err_q;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb_ps2_key_event_decoder: directed scan-byte sequences with a queued
// scoreboard; a keyboard-FIFO model feeds bytes, a monitor drains events.
module tb_ps2_key_event_decoder;
    localparam int AW = 2;

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    always #5 clk = ~clk;

    ps2_key_event_decoder_if #(.EVQ_AW(AW)) bus ();

    ps2_key_event_decoder #(.EVQ_AW(AW)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    logic [7:0]  kq [$];
    logic [15:0] exp_q [$];
    int          n_chk  = 0;
    int          n_pass = 0;
    bit          auto_rd = 1'b0;
    bit          man_rd  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Bytes are added just after a rising edge so the DUT's pop decision
    // is settled by the time the model samples it on the falling edge.
    task automatic send(input logic [7:0] b []);
        @(posedge clk);
        #2;
        foreach (b[i]) kq.push_back(b[i]);
        bus.kbd_ready = (kq.size() != 0);
        bus.kbd_data  = (kq.size() != 0) ? kq[0] : 8'h00;
    endtask

    task automatic drain();
        repeat (40) @(negedge clk);
        #1;
        chk("drain_left", exp_q.size(), 0);
        chk("drain_count", bus.ev_count, 0);
        chk("drain_data", bus.ev_data, 16'h0000);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_nextdata_n"}, bus.kbd_nextdata_n, 1);
        chk({tag, "_ev_data"}, bus.ev_data, 16'h0000);
        chk({tag, "_ev_count"}, bus.ev_count, 0);
        chk({tag, "_proto_err"}, bus.proto_err, 0);
    endtask

    // ps2_keyboard FIFO model
    initial begin
        bit pop_seen;
        bus.kbd_ready = 1'b0;
        bus.kbd_data  = 8'h00;
        forever begin
            @(negedge clk);
            pop_seen = (bus.kbd_nextdata_n === 1'b0);
            @(posedge clk);
            #1;
            if (pop_seen) begin
                if (kq.size() == 0) begin
                    chk("pop_empty", 1, 0);
                end else begin
                    void'(kq.pop_front());
                end
            end
            bus.kbd_ready = (kq.size() != 0);
            bus.kbd_data  = (kq.size() != 0) ? kq[0] : 8'h00;
        end
    end

    // Event monitor: compares and pops the head whenever reading is enabled.
    initial begin
        bus.ev_rd = 1'b0;
        forever begin
            @(negedge clk);
            bus.ev_rd = 1'b0;
            if (clrn && (auto_rd || man_rd)) begin
                if (bus.ev_data[15]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ev", bus.ev_data, 16'h0000);
                    end else begin
                        chk("ev_data", bus.ev_data, exp_q.pop_front());
                    end
                end
                bus.ev_rd = 1'b1;
                man_rd    = 1'b0;
            end
        end
    end

    initial begin
        bit got;
        bus.clr_err = 1'b0;
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        @(posedge clk);
        #2;
        clrn = 1'b1;

        // single make code, pop pulse and N+2 latency
        send('{8'h1C});
        @(negedge clk);
        chk("t1_pop_low", bus.kbd_nextdata_n, 0);
        @(negedge clk);
        chk("t1_pop_high", bus.kbd_nextdata_n, 1);
        chk("t1_count_pre", bus.ev_count, 0);
        @(negedge clk);
        chk("t1_ev", bus.ev_data, 16'h821C);
        chk("t1_count", bus.ev_count, 1);
        #1;
        exp_q.push_back(16'h821C);
        auto_rd = 1'b1;
        drain();

        // break, extended make, extended break
        exp_q.push_back(16'h801C);
        exp_q.push_back(16'h8375);
        exp_q.push_back(16'h8175);
        send('{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
        drain();

        // full queue back-pressure, wrap-around ordering
        auto_rd = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(16'h8211 + 16'(i));
        send('{8'h11, 8'h12, 8'h13, 8'h14, 8'h15});
        repeat (20) @(negedge clk);
        #1;
        chk("t3_count_full", bus.ev_count, 4);
        chk("t3_kq_left", kq.size(), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_no_pop", bus.kbd_nextdata_n, 1);
        end
        #1;
        man_rd = 1'b1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("t3_refetch", bus.kbd_nextdata_n, 0);
        chk("t3_count_freed", bus.ev_count, 3);
        auto_rd = 1'b1;
        drain();

        // protocol errors and E0 restart after F0
        exp_q.push_back(16'h8374);
        send('{8'h00, 8'hF0, 8'hE0, 8'h74});
        drain();
        chk("t4_err_set", bus.proto_err, 1);
        @(posedge clk);
        #2;
        bus.clr_err = 1'b1;
        @(posedge clk);
        #2;
        bus.clr_err = 1'b0;
        @(negedge clk);
        chk("t4_err_clr", bus.proto_err, 0);

        // simultaneous push and pop on a full-1 queue
        auto_rd = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h8221 + 16'(i));
        send('{8'h21, 8'h22, 8'h23});
        repeat (12) @(negedge clk);
        #1;
        chk("t5_count3", bus.ev_count, 3);
        send('{8'h24});
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (!bus.kbd_nextdata_n) begin
                got = 1'b1;
                break;
            end
        end
        chk("t5_pop_seen", got, 1);
        man_rd = 1'b1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("t5_count_same", bus.ev_count, 3);
        auto_rd = 1'b1;
        drain();

        // reset discards a pending E0 prefix
        send('{8'hE0});
        repeat (4) @(negedge clk);
        #1;
        clrn = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("t6");
        @(posedge clk);
        #2;
        clrn = 1'b1;
        exp_q.push_back(16'h8275);
        send('{8'h75});
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
